// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scans a frame-shadowed porch geometry, publishes active
// pixel coordinates, and drives colour plus sync to the pins with a matched 3-clock latency.
module vga_timing_gen #(
    parameter int   COUNTER_WIDTH    = 11,
    parameter int   BACKPORCH_WIDTH  = 10,
    parameter int   FRONTPORCH_WIDTH = 11,
    parameter int   DATA_WIDTH       = 12,
    parameter int   H_SYNC           = 96,
    parameter int   V_SYNC           = 2,
    parameter int   H_TAIL           = 16,
    parameter int   V_TAIL           = 10,
    parameter int   H_BP_RST         = 144,
    parameter int   H_ACT_RST        = 640,
    parameter int   V_BP_RST         = 35,
    parameter int   V_ACT_RST        = 480,
    parameter logic SYNC_POL         = 1'b0
) (
    input  logic                        Clk,
    input  logic                        rst_n,
    input  logic [BACKPORCH_WIDTH-1:0]  H_BackPorch,
    input  logic [FRONTPORCH_WIDTH-1:0] H_FrontPorch,
    input  logic [BACKPORCH_WIDTH-1:0]  V_BackPorch,
    input  logic [FRONTPORCH_WIDTH-1:0] V_FrontPorch,
    input  logic [DATA_WIDTH-1:0]       Data_VGA,
    output logic                        Counter_X_Valid,
    output logic [COUNTER_WIDTH-1:0]    Counter_X,
    output logic                        Counter_Y_Valid,
    output logic [COUNTER_WIDTH-1:0]    Counter_Y,
    output logic                        HSync,
    output logic                        VSync,
    output logic [DATA_WIDTH-1:0]       RGB,
    output logic                        Frame_Start
);

    localparam int TW = COUNTER_WIDTH + 1;

    logic [COUNTER_WIDTH-1:0]    h_cnt_r, v_cnt_r;
    logic [BACKPORCH_WIDTH-1:0]  sh_hbp_r, sh_vbp_r;
    logic [FRONTPORCH_WIDTH-1:0] sh_hact_r, sh_vact_r;
    logic [TW-1:0]               h_pos_s, v_pos_s;
    logic [TW-1:0]               h_total_s, v_total_s;
    logic [TW-1:0]               h_end_s, v_end_s;
    logic                        h_last_s, v_last_s;
    logic                        h_act_s, v_act_s;
    logic                        hs_s, vs_s, de_s;
    logic [COUNTER_WIDTH-1:0]    h_nxt_s, v_nxt_s;
    logic [COUNTER_WIDTH-1:0]    x_s, y_s;
    logic                        hs_d1_r, vs_d1_r, de_d1_r;
    logic                        hs_d2_r, vs_d2_r, de_d2_r;

    // Raster decode: totals and active-window bounds are one bit wider so they cannot overflow
    always_comb begin
        h_pos_s   = {1'b0, h_cnt_r};
        v_pos_s   = {1'b0, v_cnt_r};
        h_end_s   = TW'(sh_hbp_r) + TW'(sh_hact_r);
        v_end_s   = TW'(sh_vbp_r) + TW'(sh_vact_r);
        h_total_s = h_end_s + TW'(H_TAIL);
        v_total_s = v_end_s + TW'(V_TAIL);
        h_last_s  = (h_pos_s == (h_total_s - TW'(1)));
        v_last_s  = (v_pos_s == (v_total_s - TW'(1)));
        h_act_s   = (h_pos_s >= TW'(sh_hbp_r)) && (h_pos_s < h_end_s);
        v_act_s   = (v_pos_s >= TW'(sh_vbp_r)) && (v_pos_s < v_end_s);
        hs_s      = (h_pos_s < TW'(H_SYNC));
        vs_s      = (v_pos_s < TW'(V_SYNC));
        de_s      = h_act_s && v_act_s;
    end

    // Next raster position and active coordinates
    always_comb begin
        h_nxt_s = h_cnt_r + COUNTER_WIDTH'(1);
        v_nxt_s = v_cnt_r;
        x_s     = {COUNTER_WIDTH{1'b0}};
        y_s     = {COUNTER_WIDTH{1'b0}};
        if (h_last_s) begin
            h_nxt_s = {COUNTER_WIDTH{1'b0}};
            if (v_last_s) begin
                v_nxt_s = {COUNTER_WIDTH{1'b0}};
            end else begin
                v_nxt_s = v_cnt_r + COUNTER_WIDTH'(1);
            end
        end else begin
            v_nxt_s = v_cnt_r;
        end
        if (h_act_s) begin
            x_s = h_cnt_r - COUNTER_WIDTH'(sh_hbp_r);
        end else begin
            x_s = {COUNTER_WIDTH{1'b0}};
        end
        if (v_act_s) begin
            y_s = v_cnt_r - COUNTER_WIDTH'(sh_vbp_r);
        end else begin
            y_s = {COUNTER_WIDTH{1'b0}};
        end
    end

    // Raster counters
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= {COUNTER_WIDTH{1'b0}};
            v_cnt_r <= {COUNTER_WIDTH{1'b0}};
        end else begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Shadow geometry: sampled only on the last clock of a frame so a frame never tears
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hbp_r  <= BACKPORCH_WIDTH'(H_BP_RST);
            sh_hact_r <= FRONTPORCH_WIDTH'(H_ACT_RST);
            sh_vbp_r  <= BACKPORCH_WIDTH'(V_BP_RST);
            sh_vact_r <= FRONTPORCH_WIDTH'(V_ACT_RST);
        end else if (h_last_s && v_last_s) begin
            sh_hbp_r  <= H_BackPorch;
            sh_hact_r <= H_FrontPorch;
            sh_vbp_r  <= V_BackPorch;
            sh_vact_r <= V_FrontPorch;
        end else begin
            sh_hbp_r  <= sh_hbp_r;
            sh_hact_r <= sh_hact_r;
            sh_vbp_r  <= sh_vbp_r;
            sh_vact_r <= sh_vact_r;
        end
    end

    // Stage 1: coordinates to the colour manager, plus first sync/enable delay
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            Counter_X_Valid <= 1'b0;
            Counter_X       <= {COUNTER_WIDTH{1'b0}};
            Counter_Y_Valid <= 1'b0;
            Counter_Y       <= {COUNTER_WIDTH{1'b0}};
            Frame_Start     <= 1'b0;
            hs_d1_r         <= 1'b0;
            vs_d1_r         <= 1'b0;
            de_d1_r         <= 1'b0;
        end else begin
            Counter_X_Valid <= de_s;
            Counter_X       <= x_s;
            Counter_Y_Valid <= v_act_s;
            Counter_Y       <= y_s;
            Frame_Start     <= (h_cnt_r == {COUNTER_WIDTH{1'b0}}) && (v_cnt_r == {COUNTER_WIDTH{1'b0}});
            hs_d1_r         <= hs_s;
            vs_d1_r         <= vs_s;
            de_d1_r         <= de_s;
        end
    end

    // Stage 2: matches the colour manager's registered Data_VGA response
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d2_r <= 1'b0;
            vs_d2_r <= 1'b0;
            de_d2_r <= 1'b0;
        end else begin
            hs_d2_r <= hs_d1_r;
            vs_d2_r <= vs_d1_r;
            de_d2_r <= de_d1_r;
        end
    end

    // Stage 3: pin outputs, colour blanked outside the active window
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            RGB   <= {DATA_WIDTH{1'b0}};
            HSync <= ~SYNC_POL;
            VSync <= ~SYNC_POL;
        end else begin
            RGB   <= de_d2_r ? Data_VGA : {DATA_WIDTH{1'b0}};
            HSync <= hs_d2_r ? SYNC_POL : ~SYNC_POL;
            VSync <= vs_d2_r ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-mode instance scanned frame by frame and a
// full 640x480 instance checked over its first active line.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_full;
    logic [9:0]  hbp_in, vbp_in;
    logic [10:0] hact_in, vact_in;
    logic [11:0] data_vga;
    logic        Counter_X_Valid, Counter_Y_Valid, HSync, VSync, Frame_Start;
    logic [10:0] Counter_X, Counter_Y;
    logic [11:0] RGB;

    logic [9:0]  f_hbp = 10'd144, f_vbp = 10'd35;
    logic [10:0] f_hact = 11'd640, f_vact = 11'd480;
    logic [11:0] f_data = 12'h000;
    logic        f_xv, f_yv, f_hs, f_vs, f_fs;
    logic [10:0] f_x, f_y;
    logic [11:0] f_rgb;

    int total = 0;
    int bad   = 0;
    logic        hist_hs [2];
    logic        hist_vs [2];
    logic [11:0] hist_rgb[2];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_SYNC(2), .V_SYNC(1), .H_TAIL(2), .V_TAIL(1),
        .H_BP_RST(4), .H_ACT_RST(8), .V_BP_RST(2), .V_ACT_RST(3)
    ) u_dut (
        .Clk(clk), .rst_n(rst_n),
        .H_BackPorch(hbp_in), .H_FrontPorch(hact_in),
        .V_BackPorch(vbp_in), .V_FrontPorch(vact_in),
        .Data_VGA(data_vga),
        .Counter_X_Valid(Counter_X_Valid), .Counter_X(Counter_X),
        .Counter_Y_Valid(Counter_Y_Valid), .Counter_Y(Counter_Y),
        .HSync(HSync), .VSync(VSync), .RGB(RGB), .Frame_Start(Frame_Start)
    );

    vga_timing_gen u_full (
        .Clk(clk), .rst_n(rst_full),
        .H_BackPorch(f_hbp), .H_FrontPorch(f_hact),
        .V_BackPorch(f_vbp), .V_FrontPorch(f_vact),
        .Data_VGA(f_data),
        .Counter_X_Valid(f_xv), .Counter_X(f_x),
        .Counter_Y_Valid(f_yv), .Counter_Y(f_y),
        .HSync(f_hs), .VSync(f_vs), .RGB(f_rgb), .Frame_Start(f_fs)
    );

    // Colour manager model: one registered clock, white in blanking to prove RGB masking
    always @(posedge clk) begin
        data_vga <= Counter_X_Valid ? {Counter_X[5:0], Counter_Y[5:0]} : 12'hFFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 2; i++) begin
            hist_hs[i]  = 1'b0;
            hist_vs[i]  = 1'b0;
            hist_rgb[i] = 12'h000;
        end
    endtask

    // Scan one frame of the given geometry; optionally change HACT at (chg_v, h=0)
    task automatic run_frame(input int hbp, input int hact, input int vbp, input int vact,
                             input int chg_v, input int new_hact);
        int   htot, vtot;
        logic ha, va;
        logic [5:0] ex6, ey6;
        htot = hbp + hact + 2;
        vtot = vbp + vact + 1;
        for (int v = 0; v < vtot; v++) begin
            for (int h = 0; h < htot; h++) begin
                @(posedge clk);
                @(negedge clk);
                ha = (h >= hbp) && (h < hbp + hact);
                va = (v >= vbp) && (v < vbp + vact);
                chk("x_valid",     Counter_X_Valid, 32'(ha && va));
                chk("x",           Counter_X,       ha ? h - hbp : 0);
                chk("y_valid",     Counter_Y_Valid, 32'(va));
                chk("y",           Counter_Y,       va ? v - vbp : 0);
                chk("frame_start", Frame_Start,     32'((h == 0) && (v == 0)));
                chk("hsync",       HSync,           hist_hs[1] ? 0 : 1);
                chk("vsync",       VSync,           hist_vs[1] ? 0 : 1);
                chk("rgb",         RGB,             32'(hist_rgb[1]));
                ex6 = 6'(h - hbp);
                ey6 = 6'(v - vbp);
                hist_hs[1]  = hist_hs[0];
                hist_vs[1]  = hist_vs[0];
                hist_rgb[1] = hist_rgb[0];
                hist_hs[0]  = (h < 2);
                hist_vs[0]  = (v < 1);
                hist_rgb[0] = (ha && va) ? {ex6, ey6} : 12'h000;
                if (v == chg_v && h == 0) hact_in = 11'(new_hact);
            end
        end
    endtask

    initial begin
        int first_xv, first_yv, max_x, xv_cnt, hs_cnt, fs_cnt;
        rst_n = 1'b0; rst_full = 1'b0;
        hbp_in = 10'd4; hact_in = 11'd8; vbp_in = 10'd2; vact_in = 11'd3;
        clear_hist();
        repeat (3) @(negedge clk);
        chk("rst_x_valid", Counter_X_Valid, 0);
        chk("rst_y_valid", Counter_Y_Valid, 0);
        chk("rst_x",       Counter_X,       0);
        chk("rst_y",       Counter_Y,       0);
        chk("rst_fs",      Frame_Start,     0);
        chk("rst_rgb",     RGB,             0);
        chk("rst_hsync",   HSync,           1);
        chk("rst_vsync",   VSync,           1);

        rst_n = 1'b1;
        run_frame(4, 8, 2, 3, 3, 6);      // change arrives mid-frame, must not tear
        run_frame(4, 6, 2, 3, 1, 0);      // 12-clock lines, next frame zero-active
        run_frame(4, 0, 2, 3, 1, 8);      // no active pixels, sync keeps running
        run_frame(4, 8, 2, 3, -1, 0);

        // Into line 2, h=7 of the next frame, then reset asynchronously mid-line
        repeat (36) @(posedge clk);
        #1;
        chk("pre_rst_x_valid", Counter_X_Valid, 1);
        chk("pre_rst_x",       Counter_X,       3);
        chk("pre_rst_rgb",     RGB,             32'h040);
        #2 rst_n = 1'b0;
        #1;
        chk("async_x_valid", Counter_X_Valid, 0);
        chk("async_x",       Counter_X,       0);
        chk("async_y_valid", Counter_Y_Valid, 0);
        chk("async_rgb",     RGB,             0);
        chk("async_hsync",   HSync,           1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_hist();
        run_frame(4, 8, 2, 3, -1, 0);

        // Full 640x480 mode: first active line lands at raster position 35*800+144
        first_xv = 0; first_yv = 0; max_x = 0; xv_cnt = 0; hs_cnt = 0; fs_cnt = 0;
        @(negedge clk);
        rst_full = 1'b1;
        for (int e = 1; e <= 28145 + 700; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (f_xv) begin
                if (first_xv == 0) begin
                    first_xv = e;
                    chk("full_first_x", f_x, 0);
                    chk("full_first_y", f_y, 0);
                end
                xv_cnt++;
                if (int'(f_x) > max_x) max_x = int'(f_x);
            end
            if (f_yv && first_yv == 0) first_yv = e;
            if (e >= 4 && e <= 803 && f_hs == 1'b0) hs_cnt++;
            if (f_fs) fs_cnt++;
        end
        chk("full_first_yv_edge", first_yv, 28001);
        chk("full_first_xv_edge", first_xv, 28145);
        chk("full_max_x",         max_x,    639);
        chk("full_line_pixels",   xv_cnt,   640);
        chk("full_hsync_width",   hs_cnt,   96);
        chk("full_frame_start",   fs_cnt,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that sits directly downstream of the colour manager. Scans a pixel/line raster whose active window comes from the porch values the colour manager publishes, and returns active-region pixel coordinates so the colour manager can select a quadrant colour. Drives the registered `Data_VGA` colour it gets back to the VGA pins, together with horizontal and vertical sync pulses delayed to match that colour. Porch values are shadowed once per frame so a mode change never tears a frame.

## Interface
- `COUNTER_WIDTH`, 11: width of the raster counters and of `Counter_X`/`Counter_Y`.
- `BACKPORCH_WIDTH`, 10: width of the `*_BackPorch` inputs.
- `FRONTPORCH_WIDTH`, 11: width of the `*_FrontPorch` inputs.
- `DATA_WIDTH`, 12: colour word width.
- `H_SYNC`, 96: HSync pulse width in clocks. `V_SYNC`, 2: VSync pulse width in lines.
- `H_TAIL`, 16: idle clocks after the active pixels. `V_TAIL`, 10: idle lines after the active lines.
- `H_BP_RST`, 144; `H_ACT_RST`, 640; `V_BP_RST`, 35; `V_ACT_RST`, 480: shadow-register reset values.
- `SYNC_POL`, 0: asserted level of HSync/VSync.

Ports:
- `Clk` input 1: pixel clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `H_BackPorch` input `BACKPORCH_WIDTH`: clocks from line start (sync plus back porch) to the first active pixel.
- `H_FrontPorch` input `FRONTPORCH_WIDTH`: active pixels per line.
- `V_BackPorch` input `BACKPORCH_WIDTH`: lines from frame start to the first active line.
- `V_FrontPorch` input `FRONTPORCH_WIDTH`: active lines per frame.
- `Data_VGA` input `DATA_WIDTH`: colour from the colour manager, registered one clock after the coordinates.
- `Counter_X_Valid` output 1: high on an active pixel of an active line.
- `Counter_X` output `COUNTER_WIDTH`: active pixel index.
- `Counter_Y_Valid` output 1: high for every clock of an active line.
- `Counter_Y` output `COUNTER_WIDTH`: active line index.
- `HSync` output 1, `VSync` output 1: sync outputs, aligned with `RGB`.
- `RGB` output `DATA_WIDTH`: pixel colour to the DAC/pins.
- `Frame_Start` output 1: one-clock pulse when the raster returns to (0,0).

## Operation
- **Shadow registers.** `sh_hbp`, `sh_hact`, `sh_vbp`, `sh_vact` hold the working timing.
  - Loaded from the inputs only on the clock where `h_cnt == H_TOTAL-1` and `v_cnt == V_TOTAL-1` (last clock of a frame).
  - Input changes at any other time are ignored until the frame ends.
- **Totals.** `H_TOTAL = sh_hbp + sh_hact + H_TAIL` and `V_TOTAL = sh_vbp + sh_vact + V_TAIL`.
  - Both are computed at `COUNTER_WIDTH+1` bits so they cannot overflow.
  - Configurations guarantee `*_BackPorch > *_SYNC`; the block does not check this.
- **Raster counters.**
  - `h_cnt` increments every clock and wraps to 0 after `H_TOTAL-1`.
  - `v_cnt` increments when `h_cnt` wraps and itself wraps to 0 after `V_TOTAL-1`.
- **Active region.**
  - `h_act = (h_cnt >= sh_hbp) && (h_cnt < sh_hbp + sh_hact)`; `v_act` is defined the same way on `v_cnt`.
  - If `sh_hact == 0` or `sh_vact == 0`, there are no active pixels, but sync timing continues.
- **Coordinate outputs** (stage 1, registered from the counters):
  - `Counter_Y_Valid = v_act`.
  - `Counter_X_Valid = h_act && v_act`.
  - `Counter_X = h_cnt - sh_hbp` when `h_act`, else 0.
  - `Counter_Y = v_cnt - sh_vbp` when `v_act`, else 0.
- **Sync and enable** (raw, from the counters):
  - `hs = (h_cnt < H_SYNC)`, `vs = (v_cnt < V_SYNC)`.
  - `de = h_act && v_act`.
  - Each is delayed two stages (`*_d1`, `*_d2`) so it lines up with the `Data_VGA` response to the stage-1 coordinates.
- **Output stage** (stage 3, registered):
  - `RGB <= de_d2 ? Data_VGA : 0`.
  - `HSync <= hs_d2 ? SYNC_POL : ~SYNC_POL`; `VSync` is formed the same way from `vs_d2`.
  - `Frame_Start` is registered from `(h_cnt == 0 && v_cnt == 0)`, so it is a stage-1 signal aligned with the coordinates.
- **Reset values.**
  - Counters and all pipeline registers are 0.
  - Shadows hold the `*_RST` parameters.
  - `Counter_*`, `Counter_*_Valid`, `RGB` and `Frame_Start` are 0.
  - `HSync` and `VSync` are `~SYNC_POL` (deasserted).
- **Reset mid-frame.** Everything returns to the reset values immediately (asynchronous). After release, the first clock edge starts at `h_cnt = 0`, `v_cnt = 0`.

## Timing
- The raster position `(h_cnt, v_cnt)` at edge t appears on `Counter_*` at t+1.
- The colour manager returns `Data_VGA` at t+2.
- `RGB`, `HSync`, `VSync` for that position appear at t+3. Total latency from counter to pin is 3 clocks, identical for colour and sync.
- A new porch configuration takes effect on the first clock of the next frame. `Frame_Start` of that frame is the first output already using the new geometry.
- `Data_VGA` is ignored whenever `de_d2 = 0`; `RGB` is forced to 0 in blanking.

## Test plan
- **Small mode.** `H_SYNC=2`, `V_SYNC=1`, `H_TAIL=2`, `V_TAIL=1`; inputs `HBP=4`, `HACT=8`, `VBP=2`, `VACT=3`; reset shadows equal to these inputs.
  - Line is 14 clocks, frame is 6 lines.
  - `Counter_X` reads 0..7 on clocks 5..12 of each of lines 2..4.
  - `HSync` asserts for 2 clocks per line. `Frame_Start` pulses every 84 clocks.
- **Alignment.** Drive `Data_VGA = {Counter_X, Counter_Y}` through a 1-clock model.
  - `RGB` equals the pixel's coordinates exactly 3 clocks after the counter.
  - `RGB` is 0 in blanking even when `Data_VGA = 12'hFFF`.
- **Mid-frame change.** Change to `HACT=6` during line 3.
  - The current frame keeps 8 active pixels per line.
  - The next frame has 6 pixels (`Counter_X` 0..5) and a 12-clock line.
- **Zero active.** `HACT=0`.
  - `Counter_X_Valid` and `RGB` stay 0 for the whole frame.
  - `HSync` and `VSync` keep their period.
- **Async reset.** Assert `rst_n=0` mid-line.
  - Outputs go to reset values within the same clock.
  - After release, `Frame_Start` pulses at t+1 and `HSync` asserts at t+3.
- **Full mode.** Full 640x480 defaults.
  - 800×525 clocks per frame; `Counter_X` max 639, `Counter_Y` max 479.
